// File: rtl/register_stream_reader.sv
// Snapshots a DEPTH-word register bank on start and streams it out one word
// per valid/ready handshake; writers may keep updating data_in meanwhile.
module register_stream_reader_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clock or negedge reset)
    if (!reset)    q <= '0;
    else if (load) q <= d;
endmodule

module register_stream_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DEPTH*DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INDEX_WIDTH-1:0]      out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(DEPTH-1);

  state_t                           state;
  logic [INDEX_WIDTH-1:0]           index;
  logic [INDEX_WIDTH-1:0]           nxt_index;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] shadow;
  logic                             load;
  logic                             xfer;

  assign load      = (state == IDLE) && start;
  assign xfer      = out_valid && out_ready;
  assign nxt_index = index + 1'b1;

  // One shadow slot per word, all captured on the same start edge.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    register_stream_reader_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .d     (data_in[gi*DATA_WIDTH +: DATA_WIDTH]),
      .q     (shadow[gi])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      index     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          // Word 0 comes straight from data_in since the shadow loads this edge.
          state     <= STREAM;
          index     <= '0;
          out_valid <= 1'b1;
          out_data  <= data_in[DATA_WIDTH-1:0];
          out_index <= '0;
          out_last  <= 1'b0;
          busy      <= 1'b1;
        end
        STREAM: if (xfer) begin
          if (index == LAST) begin
            state     <= DONE;
            index     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            done      <= 1'b1;
          end else begin
            index     <= nxt_index;
            out_data  <= shadow[nxt_index];
            out_index <= nxt_index;
            out_last  <= (nxt_index == LAST);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_stream_reader.sv
// Directed + randomized bench for register_stream_reader; expected words come
// from a snapshot queue of data_in taken when start is issued.
module tb_register_stream_reader;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [DEPTH*DW-1:0]   data_in = '0;
  logic [DW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [IW-1:0]         out_index;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  int vectors = 0;
  int errs    = 0;
  logic [DW-1:0] exp_q [DEPTH];
  bit   [7:0]    bp_pat = 8'b1011_0100; // bit p = ready on step p: 0,0,1,0,1,1,0,1

  register_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INDEX_WIDTH(IW)) dut (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_last"},  out_last, 0);
  endtask

  task automatic rand_data();
    for (int i = 0; i < DEPTH; i++) data_in[i*DW +: DW] = $urandom;
  endtask

  // Model snapshot: whatever data_in holds at the start edge is the stream.
  task automatic begin_stream();
    for (int i = 0; i < DEPTH; i++) exp_q[i] = data_in[i*DW +: DW];
    start = 1'b1; out_ready = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    chk("first_valid", out_valid, 1);
    chk("first_busy",  busy, 1);
  endtask

  // mode 0: ready always, 1: backpressure pattern, 2: random ready.
  task automatic drain(input int mode, input int start_at, input int rst_at, input bit chg);
    int  n = 0;
    int  cyc = 0;
    logic rdy;
    while (n < DEPTH && cyc < 200) begin
      chk("valid", out_valid, 1);
      chk("busy",  busy, 1);
      chk("done_early", done, 0);
      chk("data",  out_data, exp_q[n]);
      chk("index", out_index, n);
      chk("last",  out_last, (n == DEPTH-1));
      if (rst_at == n) begin
        @(negedge clock); reset = 1'b0; #1;
        chk_idle("rst_mid");
        @(negedge clock); reset = 1'b1;
        return;
      end
      start = (start_at == n);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = bp_pat[cyc % 8];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (chg && cyc == 0) data_in = {DEPTH{32'h12345678}};
      tick();
      start = 1'b0;
      cyc++;
      if (rdy) n++;
    end
    chk("xfer_count", n, DEPTH);
    if (mode == 0) chk("b2b_cycles", cyc, DEPTH);
    chk("end_valid", out_valid, 0);
    chk("end_last",  out_last, 0);
    chk("done_pulse", done, 1);
    chk("done_busy",  busy, 1);
    out_ready = 1'($urandom_range(0, 1));
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_valid", out_valid, 0);
  endtask

  initial begin
    // Reset held with start high and random data.
    start = 1'b1; rand_data();
    tick(); tick();
    chk_idle("reset");
    @(negedge clock); reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk_idle("idle");

    // Basic stream, back-to-back.
    data_in = {32'hFFFFFFFF, 32'h00000001, 32'h5A5A5A5A, 32'hA5A5A5A5};
    begin_stream();
    drain(0, -1, -1, 1'b0);
    chk_idle("after_basic");

    // Backpressure.
    data_in = {32'hFFFFFFFF, 32'h00000001, 32'h5A5A5A5A, 32'hA5A5A5A5};
    begin_stream();
    drain(1, -1, -1, 1'b0);

    // Snapshot isolation.
    data_in = {32'hFFFFFFFF, 32'h00000001, 32'h5A5A5A5A, 32'hA5A5A5A5};
    begin_stream();
    drain(2, -1, -1, 1'b1);

    // Start during stream is ignored; start after done restarts at index 0.
    rand_data();
    begin_stream();
    drain(0, 2, -1, 1'b0);
    chk_idle("no_restart");
    rand_data();
    begin_stream();
    chk("fresh_index", out_index, 0);
    drain(2, -1, -1, 1'b0);

    // Reset mid-stream, then a new snapshot.
    rand_data();
    begin_stream();
    drain(0, -1, 1, 1'b0);
    tick();
    chk_idle("after_rst");
    rand_data();
    begin_stream();
    drain(2, -1, -1, 1'b0);

    // Random streams with random data and ready.
    for (int k = 0; k < 6; k++) begin
      rand_data();
      begin_stream();
      drain(2, -1, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/register_stream_reader.md
Name: register_stream_reader

Overview:
- Read-side counterpart of the 32-bit parameter register: snapshots a bank of DEPTH parallel registers and streams them out one word per valid/ready handshake.
- Sits between local weight/bias registers and the federated aggregation/transmit path, so model parameters can be unloaded serially without stalling the writers.
- The writer may keep updating the source registers during a stream; the output is always the snapshot taken at start.

Parameters:
DATA_WIDTH, 32, width of one register word
DEPTH, 8, number of registers in the bank (>=2)
INDEX_WIDTH, 3, width of out_index; must be >= clog2(DEPTH)

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
start  input  1  request snapshot and stream; sampled only in IDLE
data_in  input  DEPTH*DATA_WIDTH  flattened register bank; word i = data_in[i*DATA_WIDTH +: DATA_WIDTH]
out_data  output  DATA_WIDTH  current word
out_valid  output  1  out_data/out_index/out_last are valid
out_ready  input  1  downstream accepts the word
out_index  output  INDEX_WIDTH  index of the current word
out_last  output  1  current word is index DEPTH-1
busy  output  1  high in STREAM and DONE
done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (reset=0, async): state=IDLE; shadow bank cleared to 0; index=0; out_data=0; out_valid=0; out_last=0; out_index=0; busy=0; done=0. Reset deasserts synchronously to clock.
- States: IDLE, STREAM, DONE.
- IDLE, start=1 at edge k: all DEPTH words of data_in copied to the shadow bank; index=0; state goes to STREAM. From edge k: out_valid=1, out_data=word 0, busy=1. Latency from start to first valid is one edge.
- IDLE, start=0: all outputs hold their reset values except done (see DONE).
- STREAM: out_data=shadow[index]; out_index=index; out_last=(index==DEPTH-1).
- Transfer occurs on an edge where out_valid=1 and out_ready=1.
  - Transfer with index<DEPTH-1: index increments; the next word is presented at the same edge. Back-to-back transfers are possible every cycle.
  - Transfer with index==DEPTH-1: out_valid=0, out_last=0, and state goes to DONE.
- out_valid=1 with out_ready=0: out_data, out_index and out_last hold stable; out_valid never drops before the transfer.
- DONE lasts exactly one cycle: done=1 and busy=1; then state goes to IDLE, with done=0 and busy=0.
- start is ignored in STREAM and DONE: no re-snapshot and no restart. start high in the IDLE cycle after DONE begins a new stream.
- data_in changes after the snapshot do not affect the stream in progress.
- Index wrap: index never exceeds DEPTH-1 and resets to 0 on each start.
- out_ready is a don't-care while out_valid=0.
- Reset mid-stream: everything returns to reset values immediately, with no done pulse. The stream is not resumed; a new start is needed.
- Exactly DEPTH transfers per start; no words are dropped or duplicated.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with start=1 and data_in random -> out_valid=0, busy=0, done=0, out_data=0. After release with start=0, all outputs stay 0.
2. Basic stream, DEPTH=4: data_in words = {A5A5A5A5, 5A5A5A5A, 00000001, FFFFFFFF}, start pulsed for 1 cycle, out_ready=1 constant.
   - Words appear on 4 consecutive cycles in that order with out_index 0..3.
   - out_last=1 only on FFFFFFFF.
   - done pulses 1 cycle later; busy falls the cycle after that.
3. Backpressure: same data, out_ready toggled 0,0,1,0,1,1,0,1.
   - out_data and out_index hold while out_ready=0.
   - Exactly 4 transfers occur, in order, with no duplicates.
4. Snapshot isolation: change data_in to all 12345678 one cycle after start -> streamed words are still the original four values.
5. Start during stream: pulse start while out_index=2 -> stream completes unchanged with a single done pulse. A start in IDLE after done begins a fresh stream from index 0.
6. Reset mid-stream: assert reset=0 while out_index=1 -> out_valid, busy and done drop to 0 asynchronously with no done pulse. A subsequent start streams from index 0 with the new snapshot.
